// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle LEGv8 controller: FSM state
// encoding, opcode classes, opcode constants/masks and ALU-op encodings.
package ctrl_pkg;

  // Controller states; the numeric encoding is visible on the debug port.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_ALU   = 4'd7,
    WB_MEM   = 4'd8,
    BRANCH   = 4'd9,
    HALT     = 4'd10
  } state_e;

  // Instruction classes produced by the opcode classifier.
  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_I       = 3'd1,
    CLS_LD      = 3'd2,
    CLS_ST      = 3'd3,
    CLS_CBZ     = 3'd4,
    CLS_ILLEGAL = 3'd5
  } opc_class_e;

  // Full 11-bit opcodes (IR[31:21]).
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;

  // ADDI and CBZ have short opcodes; the mask keeps only the defined bits.
  localparam logic [10:0] OPC_ADDI  = 11'b10010001000;
  localparam logic [10:0] MASK_ADDI = 11'b11111111110;
  localparam logic [10:0] OPC_CBZ   = 11'b10110100000;
  localparam logic [10:0] MASK_CBZ  = 11'b11111111000;

  // ALU decoder operation select.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_R     = 2'b10;
  localparam logic [1:0] ALUOP_I     = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_opc_class.sv
// Combinational opcode classifier: maps an 11-bit LEGv8 opcode onto one of
// the controller's instruction classes.
module opc_class
  import ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output logic [2:0]  cls
);

  // Exact matches first, then the masked short opcodes; anything else is illegal.
  always_comb begin
    cls = CLS_ILLEGAL;
    if (opcode == OPC_ADD || opcode == OPC_SUB ||
        opcode == OPC_AND || opcode == OPC_ORR) begin
      cls = CLS_R;
    end else if ((opcode & MASK_ADDI) == OPC_ADDI) begin
      cls = CLS_I;
    end else if (opcode == OPC_LDUR) begin
      cls = CLS_LD;
    end else if (opcode == OPC_STUR) begin
      cls = CLS_ST;
    end else if ((opcode & MASK_CBZ) == OPC_CBZ) begin
      cls = CLS_CBZ;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 controller (LDUR, STUR, CBZ, ADD, SUB, AND, ORR, ADDI).
// Moore-style FSM sequencing a shared ALU / memory port / register file, with
// a req/ack memory handshake guarded by a wait-cycle timeout.
// Optional macro ILLEGAL_TRAP_EN: undecoded opcodes set a sticky trap and
// halt; without it they behave as a NOP and trap is tied low.
//
// Memory handshake: mem_req is held high, with mem_we stable, from the first
// cycle of FETCH/MEM_RD/MEM_WR until the cycle in which mem_ack is high; that
// cycle completes the transfer. mem_ack in a cycle with mem_req low is ignored.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg2loc,
  output logic        alusrc,
  output logic [1:0]  aluop,
  output logic        mem2reg,
  output logic        reg_write,
  output logic        mem_err,
  output logic        trap,
  output logic [3:0]  state_dbg
);

  // Last allowed wait count: the no-ack cycle seen at this count times out.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_e     state;
  state_e     state_next;
  logic [7:0] wait_cnt;
  logic [2:0] cls;
  logic       timeout_hit;
  logic       err_set;
  logic       mem_err_q;

  logic       req_c;
  logic       we_c;
  logic       ir_write_c;
  logic       pc_write_c;
  logic       pc_src_c;
  logic       reg2loc_c;
  logic       alusrc_c;
  logic [1:0] aluop_c;
  logic       mem2reg_c;
  logic       reg_write_c;

`ifdef ILLEGAL_TRAP_EN
  logic       trap_set;
  logic       trap_q;
`endif

  opc_class u_opc_class (
    .opcode (opcode),
    .cls    (cls)
  );

  assign timeout_hit = (wait_cnt == TIMEOUT_LAST) && !mem_ack;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  // Wait counter: cleared on every state change, counts unacknowledged request cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     wait_cnt <= 8'd0;
    else if (state_next != state)   wait_cnt <= 8'd0;
    else if (req_c && !mem_ack)     wait_cnt <= wait_cnt + 8'd1;
  end

  // Sticky memory timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       mem_err_q <= 1'b0;
    else if (err_set) mem_err_q <= 1'b1;
  end

  // Next-state and control outputs; ack is checked before timeout so ack wins.
  always_comb begin
    state_next  = state;
    req_c       = 1'b0;
    we_c        = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    pc_src_c    = 1'b0;
    reg2loc_c   = 1'b0;
    alusrc_c    = 1'b0;
    aluop_c     = ALUOP_ADD;
    mem2reg_c   = 1'b0;
    reg_write_c = 1'b0;
    err_set     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    trap_set    = 1'b0;
`endif
    case (state)
      FETCH: begin
        req_c = 1'b1;
        if (mem_ack) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_next = DECODE;
        end else if (timeout_hit) begin
          err_set    = 1'b1;
          state_next = HALT;
        end
      end
      DECODE: begin
        case (cls)
          CLS_R:          state_next = EXEC_R;
          CLS_I:          state_next = EXEC_I;
          CLS_LD, CLS_ST: state_next = MEM_ADDR;
          CLS_CBZ:        state_next = BRANCH;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            trap_set   = 1'b1;
            state_next = HALT;
`else
            state_next = FETCH;
`endif
          end
        endcase
      end
      EXEC_R: begin
        aluop_c    = ALUOP_R;
        state_next = WB_ALU;
      end
      EXEC_I: begin
        aluop_c    = ALUOP_I;
        alusrc_c   = 1'b1;
        state_next = WB_ALU;
      end
      WB_ALU: begin
        // IR is still stable, so the class tells which EXEC state preceded.
        reg_write_c = 1'b1;
        if (cls == CLS_I) begin
          aluop_c  = ALUOP_I;
          alusrc_c = 1'b1;
        end else begin
          aluop_c  = ALUOP_R;
        end
        state_next = FETCH;
      end
      MEM_ADDR: begin
        aluop_c    = ALUOP_ADD;
        alusrc_c   = 1'b1;
        reg2loc_c  = 1'b1;
        state_next = (cls == CLS_ST) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        req_c = 1'b1;
        if (mem_ack) begin
          state_next = WB_MEM;
        end else if (timeout_hit) begin
          err_set    = 1'b1;
          state_next = HALT;
        end
      end
      MEM_WR: begin
        req_c = 1'b1;
        we_c  = 1'b1;
        if (mem_ack) begin
          state_next = FETCH;
        end else if (timeout_hit) begin
          err_set    = 1'b1;
          state_next = HALT;
        end
      end
      WB_MEM: begin
        reg_write_c = 1'b1;
        mem2reg_c   = 1'b1;
        state_next  = FETCH;
      end
      BRANCH: begin
        aluop_c   = ALUOP_PASSB;
        reg2loc_c = 1'b1;
        if (zero) begin
          pc_write_c = 1'b1;
          pc_src_c   = 1'b1;
        end
        state_next = FETCH;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  // Sticky illegal-opcode flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        trap_q <= 1'b0;
    else if (trap_set) trap_q <= 1'b1;
  end
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  // Reset forces every strobe low immediately, even though FETCH is the reset state.
  assign mem_req   = reset & req_c;
  assign mem_we    = reset & we_c;
  assign ir_write  = reset & ir_write_c;
  assign pc_write  = reset & pc_write_c;
  assign pc_src    = reset & pc_src_c;
  assign reg2loc   = reset & reg2loc_c;
  assign alusrc    = reset & alusrc_c;
  assign aluop     = aluop_c & {2{reset}};
  assign mem2reg   = reset & mem2reg_c;
  assign reg_write = reset & reg_write_c;
  assign mem_err   = mem_err_q;
  assign state_dbg = state;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore FSM that sequences the shared datapath (one ALU, one memory port, register file) over several cycles per instruction for the LEGv8 subset LDUR, STUR, CBZ, ADD, SUB, AND, ORR, ADDI.
- Drives aluop into the existing ALU control decoder, and the enables/selects into PC, IR, memory and register file.
- Handles variable-latency memory through a req/ack handshake with a timeout.

Parameters:
TIMEOUT, 255, max cycles a memory request may wait for ack before mem_err (1..255; 8-bit counter).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode  in  11  IR[31:21], valid from DECODE onward
zero  in  1  ALU zero flag, sampled in BRANCH
mem_ack  in  1  memory completed current request
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write (STUR), 0 = read
ir_write  out  1  latch fetched word into IR
pc_write  out  1  update PC
pc_src  out  1  0 = PC+4, 1 = PC+branch offset
reg2loc  out  1  Rm/Rt select for read port 2
alusrc  out  1  0 = register, 1 = immediate
aluop  out  2  to ALU decoder: 00 add, 01 pass B, 10 R-type, 11 I-type
mem2reg  out  1  write-back source: 1 = memory
reg_write  out  1  register file write enable
mem_err  out  1  sticky memory timeout flag
trap  out  1  illegal opcode (see Optional Feature)

Behaviour:
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, HALT.
- Reset (reset=0, async): state=FETCH, wait counter=0, mem_err=0, trap=0. All outputs are 0 while reset is asserted.
- FETCH: mem_req=1, mem_we=0. On mem_ack: ir_write=1, pc_write=1, pc_src=0, then DECODE.
- DECODE routing:
  - ADD/SUB/AND/ORR -> EXEC_R
  - ADDI (1001000100x) -> EXEC_I
  - LDUR/STUR -> MEM_ADDR
  - CBZ (10110100xxx) -> BRANCH
  - other -> illegal handling
- EXEC_R: aluop=10, alusrc=0, reg2loc=0 -> WB_ALU.
- EXEC_I: aluop=11, alusrc=1 -> WB_ALU.
- WB_ALU: reg_write=1, mem2reg=0; aluop/alusrc held from previous state -> FETCH.
- MEM_ADDR: aluop=00, alusrc=1, reg2loc=1 -> MEM_RD (LDUR) or MEM_WR (STUR).
- MEM_RD: mem_req=1, mem_we=0; on ack -> WB_MEM. MEM_WR: mem_req=1, mem_we=1; on ack -> FETCH.
- WB_MEM: reg_write=1, mem2reg=1 -> FETCH.
- BRANCH: aluop=01, reg2loc=1. If zero=1, pc_write=1 and pc_src=1; else no PC update. -> FETCH.
- Per-instruction cycle counts with ack in the first cycle:
  - R/I: 4
  - LDUR: 5
  - STUR: 4
  - CBZ: 3
- Handshake: mem_req stays high, with stable mem_we, until the cycle mem_ack=1. ack while mem_req=0 is ignored.
- Wait counter: clears on state entry, increments each cycle mem_req=1 && mem_ack=0.
- Timeout: counter reaching TIMEOUT with no ack -> mem_err=1, go to HALT.
- HALT: all enables 0. Left only by reset.
- Simultaneous ack and timeout in the same cycle: ack wins, no error.
- Reset mid-instruction: abandons it immediately. No write enables are asserted after reset deasserts until a new FETCH completes.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an undecoded opcode in DECODE sets trap=1 (sticky) and goes to HALT.
- Undefined: an undecoded opcode is a NOP (DECODE -> FETCH, no reg/mem writes; PC already advanced) and trap is tied 0.

Decomposition:
- Shared package (ctrl_pkg): state enum typedef, opcode constants for the ISA subset (with wildcard masks for ADDI and CBZ), aluop encodings (ALUOP_ADD, ALUOP_PASSB, ALUOP_R, ALUOP_I).
- One sub-module: opc_class, a combinational classifier from opcode to {R, I, LD, ST, CBZ, ILLEGAL}, reused by DECODE and the bench.

Test Plan:
- ADD, opcode 10001011000, ack on first request cycle -> states FETCH, DECODE, EXEC_R, WB_ALU; aluop=10 in EXEC_R; reg_write pulses exactly once; 4 cycles.
- LDUR, opcode 11111000010, data ack delayed 3 cycles -> mem_req held 4 cycles with mem_we=0; WB_MEM asserts reg_write=1 and mem2reg=1.
- CBZ, opcode 10110100000: zero=1 -> pc_write=1 and pc_src=1 in BRANCH. Repeat with zero=0 -> no pc_write in BRANCH.
- STUR with mem_ack never asserted -> mem_err rises after 255 wait cycles; HALT entered; all enables 0 until reset.
- Opcode 00000000000: with ILLEGAL_TRAP_EN, trap=1 and HALT. Without it, returns to FETCH with no reg_write or mem_req.
- reset pulled low during MEM_WR while mem_req=1 -> mem_req=0 immediately (async). After release, state=FETCH and mem_err=0.
